// File: rtl/miriscv_mdu_pkg.sv
// MDU opcode encodings and the issue-stage FSM state type.
package miriscv_mdu_pkg;

  localparam int MDU_OP_WIDTH = 3;

  // MDU opcodes, in RV32M funct3 order.
  typedef enum logic [MDU_OP_WIDTH-1:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  // Issue stage: IDLE waits for a request, EXEC drives the MDU,
  // HOLD presents the captured result to writeback.
  typedef enum logic [1:0] {
    MDU_ISSUE_IDLE = 2'd0,
    MDU_ISSUE_EXEC = 2'd1,
    MDU_ISSUE_HOLD = 2'd2
  } mdu_issue_state_e;

endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide configuration shared by all miriscv blocks.
package miriscv_pkg;

  // Integer register / datapath width.
  localparam int XLEN = 32;

endpackage

// File: rtl/miriscv_mdu_rescache.sv
// Single-entry result cache for the MDU issue stage: remembers the last
// {op, a, b} -> result computed by the MDU and reports a hit on a match.
// Only instantiated when MIRISCV_MDU_RESULT_CACHE_EN is defined.
module miriscv_mdu_rescache
  import miriscv_pkg::*;
  import miriscv_mdu_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [MDU_OP_WIDTH-1:0] wr_op_i,
  input  logic [XLEN-1:0]         wr_a_i,
  input  logic [XLEN-1:0]         wr_b_i,
  input  logic [XLEN-1:0]         wr_result_i,
  input  logic [MDU_OP_WIDTH-1:0] lk_op_i,
  input  logic [XLEN-1:0]         lk_a_i,
  input  logic [XLEN-1:0]         lk_b_i,
  output logic                    hit_o,
  output logic [XLEN-1:0]         hit_result_o
);

  logic                    valid_q, valid_d;
  logic [MDU_OP_WIDTH-1:0] op_q, op_d;
  logic [XLEN-1:0]         a_q, a_d;
  logic [XLEN-1:0]         b_q, b_d;
  logic [XLEN-1:0]         result_q, result_d;

  // Overwrite the entry on every fresh MDU result; only reset invalidates it.
  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    if (wr_en_i) begin
      valid_d  = 1'b1;
      op_d     = wr_op_i;
      a_d      = wr_a_i;
      b_d      = wr_b_i;
      result_d = wr_result_i;
    end
  end

  // Entry registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      valid_q  <= valid_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Combinational lookup against the incoming request.
  always_comb begin
    hit_o        = valid_q && (op_q == lk_op_i) && (a_q == lk_a_i) && (b_q == lk_b_i);
    hit_result_o = result_q;
  end

endmodule

// File: rtl/miriscv_mdu_issue.sv
// MDU issue stage: accepts one request, drives the MDU until it stops
// stalling, and holds the result for writeback.
// Optional feature: MIRISCV_MDU_RESULT_CACHE_EN adds a single-entry result
// cache that lets a repeated {op, a, b} skip the MDU entirely.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both 1.
// The sender keeps valid and payload steady until that cycle; ready may
// depend combinationally on the receiver's state and on flush_i/rsp_ready_i.
module miriscv_mdu_issue
  import miriscv_pkg::*;
  import miriscv_mdu_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [MDU_OP_WIDTH-1:0] req_op_i,
  input  logic [XLEN-1:0]         req_a_i,
  input  logic [XLEN-1:0]         req_b_i,
  input  logic [4:0]              req_rd_i,
  input  logic                    flush_i,
  output logic                    mdu_req_o,
  output logic [MDU_OP_WIDTH-1:0] mdu_op_o,
  output logic [XLEN-1:0]         mdu_port_a_o,
  output logic [XLEN-1:0]         mdu_port_b_o,
  output logic                    mdu_kill_o,
  output logic                    mdu_keep_o,
  input  logic [XLEN-1:0]         mdu_result_i,
  input  logic                    mdu_stall_req_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [XLEN-1:0]         rsp_result_o,
  output logic [4:0]              rsp_rd_o
);

  mdu_issue_state_e        state_q, state_d;
  logic [MDU_OP_WIDTH-1:0] op_q, op_d;
  logic [XLEN-1:0]         a_q, a_d;
  logic [XLEN-1:0]         b_q, b_d;
  logic [4:0]              rd_q, rd_d;
  logic [XLEN-1:0]         result_q, result_d;

  logic accept;
  logic capture;

  // A new request may enter when idle, or when the held result leaves this
  // same cycle; a flush blocks entry so nothing from the flushed stream slips in.
  always_comb begin
    req_ready_o = !flush_i && ((state_q == MDU_ISSUE_IDLE) ||
                               ((state_q == MDU_ISSUE_HOLD) && rsp_ready_i));
    accept      = req_valid_i && req_ready_o;
    capture     = (state_q == MDU_ISSUE_EXEC) && !flush_i && !mdu_stall_req_i;
  end

`ifdef MIRISCV_MDU_RESULT_CACHE_EN
  logic            cache_hit;
  logic [XLEN-1:0] cache_result;

  miriscv_mdu_rescache u_rescache (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (capture),
    .wr_op_i      (op_q),
    .wr_a_i       (a_q),
    .wr_b_i       (b_q),
    .wr_result_i  (mdu_result_i),
    .lk_op_i      (req_op_i),
    .lk_a_i       (req_a_i),
    .lk_b_i       (req_b_i),
    .hit_o        (cache_hit),
    .hit_result_o (cache_result)
  );
`endif

  // Next-state, operand/result capture and MDU kill.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rd_d       = rd_q;
    result_d   = result_q;
    mdu_kill_o = 1'b0;

    case (state_q)
      MDU_ISSUE_IDLE: begin
        if (accept) state_d = MDU_ISSUE_EXEC;
      end
      MDU_ISSUE_EXEC: begin
        if (flush_i) begin
          // The MDU may be mid-division; tell it to abandon the op.
          mdu_kill_o = 1'b1;
          state_d    = MDU_ISSUE_IDLE;
        end else if (!mdu_stall_req_i) begin
          result_d = mdu_result_i;
          state_d  = MDU_ISSUE_HOLD;
        end
      end
      MDU_ISSUE_HOLD: begin
        if (flush_i) begin
          state_d = MDU_ISSUE_IDLE;
        end else if (rsp_ready_i) begin
          state_d = accept ? MDU_ISSUE_EXEC : MDU_ISSUE_IDLE;
        end
      end
      default: state_d = MDU_ISSUE_IDLE;
    endcase

    if (accept) begin
      op_d = req_op_i;
      a_d  = req_a_i;
      b_d  = req_b_i;
      rd_d = req_rd_i;
    end

`ifdef MIRISCV_MDU_RESULT_CACHE_EN
    // A repeated computation goes straight to HOLD with the remembered value.
    if (accept && cache_hit) begin
      state_d  = MDU_ISSUE_HOLD;
      result_d = cache_result;
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MDU_ISSUE_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

  // Registered-state outputs toward the MDU and writeback.
  always_comb begin
    mdu_req_o    = (state_q == MDU_ISSUE_EXEC);
    mdu_op_o     = op_q;
    mdu_port_a_o = a_q;
    mdu_port_b_o = b_q;
    rsp_valid_o  = (state_q == MDU_ISSUE_HOLD);
    mdu_keep_o   = (state_q == MDU_ISSUE_HOLD) && !rsp_ready_i;
    rsp_result_o = result_q;
    rsp_rd_o     = rd_q;
  end

endmodule

// File: tb/tb_miriscv_mdu_issue.sv
// Directed testbench for miriscv_mdu_issue with a behavioural MDU model
// whose stall length is set per operation.
module tb_miriscv_mdu_issue;
  import miriscv_pkg::*;
  import miriscv_mdu_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    req_valid;
  logic                    req_ready;
  logic [MDU_OP_WIDTH-1:0] req_op;
  logic [XLEN-1:0]         req_a, req_b;
  logic [4:0]              req_rd;
  logic                    flush;
  logic                    mdu_req;
  logic [MDU_OP_WIDTH-1:0] mdu_op;
  logic [XLEN-1:0]         mdu_a, mdu_b;
  logic                    mdu_kill, mdu_keep;
  logic [XLEN-1:0]         mdu_result;
  logic                    mdu_stall;
  logic                    rsp_valid, rsp_ready;
  logic [XLEN-1:0]         rsp_result;
  logic [4:0]              rsp_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cfg = 0;
  int exec_cnt  = 0;

  miriscv_mdu_issue dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_op_i        (req_op),
    .req_a_i         (req_a),
    .req_b_i         (req_b),
    .req_rd_i        (req_rd),
    .flush_i         (flush),
    .mdu_req_o       (mdu_req),
    .mdu_op_o        (mdu_op),
    .mdu_port_a_o    (mdu_a),
    .mdu_port_b_o    (mdu_b),
    .mdu_kill_o      (mdu_kill),
    .mdu_keep_o      (mdu_keep),
    .mdu_result_i    (mdu_result),
    .mdu_stall_req_i (mdu_stall),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .rsp_rd_o        (rsp_rd)
  );

  // MDU model: stalls for stall_cfg cycles of each EXEC stay, then answers.
  always @(posedge clk) begin
    if (mdu_req) exec_cnt <= exec_cnt + 1;
    else         exec_cnt <= 0;
  end
  assign mdu_stall = mdu_req && (exec_cnt < stall_cfg);

  logic [63:0] prod;
  always_comb begin
    prod = {32'b0, mdu_a} * {32'b0, mdu_b};
    case (mdu_op)
      MDU_MUL:   mdu_result = prod[31:0];
      MDU_MULHU: mdu_result = prod[63:32];
      MDU_DIV:   mdu_result = (mdu_b == 0) ? '1 : $signed(mdu_a) / $signed(mdu_b);
      MDU_REM:   mdu_result = (mdu_b == 0) ? mdu_a : $signed(mdu_a) % $signed(mdu_b);
      default:   mdu_result = '0;
    endcase
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_mdu_req"},   {31'b0, mdu_req},   32'd0);
    chk({tag, "_kill"},      {31'b0, mdu_kill},  32'd0);
    chk({tag, "_keep"},      {31'b0, mdu_keep},  32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_result"}, rsp_result,        32'd0);
    chk({tag, "_rsp_rd"},    {27'b0, rsp_rd},    32'd0);
    chk({tag, "_port_a"},    mdu_a,              32'd0);
    chk({tag, "_port_b"},    mdu_b,              32'd0);
    chk({tag, "_op"},        {29'b0, mdu_op},    32'd0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    flush = 1'b0; rsp_ready = 1'b1;

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");

    // MUL 3*5, no stall: one EXEC cycle, rsp at N+2
    stall_cfg = 0;
    send(MDU_MUL, 32'd3, 32'd5, 5'd7);
    #1 chk("mul_accept_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("mul_n1_exec", {28'b0, mdu_req, mdu_a == 32'd3, mdu_b == 32'd5, rsp_valid}, 32'hE);
    chk("mul_n1_op", {29'b0, mdu_op}, 32'd0);
    tick();
    chk("mul_n2_valid", {31'b0, rsp_valid}, 32'd1);
    chk("mul_n2_result", rsp_result, 32'd15);
    chk("mul_n2_rd", {27'b0, rsp_rd}, 32'd7);
    chk("mul_n2_mdu_req", {31'b0, mdu_req}, 32'd0);
    tick();
    chk("mul_n3_idle", {30'b0, rsp_valid, req_ready}, 32'd1);

    // DIV 100/7 with 33 stall cycles: 34 EXEC cycles, result at N+35
    stall_cfg = 33;
    send(MDU_DIV, 32'd100, 32'd7, 5'd9);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 34; i++) begin
      #1;
      chk("div_exec_stable", {27'b0, mdu_req, mdu_op == 3'd4, mdu_a == 32'd100,
                              mdu_b == 32'd7, rsp_valid}, 32'h1E);
      tick();
    end
    chk("div_valid", {31'b0, rsp_valid}, 32'd1);
    chk("div_result", rsp_result, 32'd14);
    chk("div_rd", {27'b0, rsp_rd}, 32'd9);
    tick();
    stall_cfg = 0;

    // Writeback back-pressure 5 cycles, then back-to-back accept
    rsp_ready = 1'b0;
    send(MDU_MUL, 32'd6, 32'd7, 5'd3);
    tick();
    req_valid = 1'b0;
    #1 chk("bp_exec", {31'b0, mdu_req}, 32'd1);
    tick();
    send(MDU_MUL, 32'd2, 32'd9, 5'd4);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_flags", {28'b0, rsp_valid, mdu_keep, req_ready, mdu_req}, 32'hC);
      chk("bp_hold_result", rsp_result, 32'd42);
      chk("bp_hold_rd", {27'b0, rsp_rd}, 32'd3);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_flags", {29'b0, rsp_valid, mdu_keep, req_ready}, 32'h5);
    chk("bp_release_result", rsp_result, 32'd42);
    tick();
    req_valid = 1'b0;
    #1;
    chk("b2b_exec", {28'b0, mdu_req, mdu_a == 32'd2, mdu_b == 32'd9, rsp_valid}, 32'hE);
    tick();
    chk("b2b_valid", {31'b0, rsp_valid}, 32'd1);
    chk("b2b_result", rsp_result, 32'd18);
    chk("b2b_rd", {27'b0, rsp_rd}, 32'd4);
    tick();

    // Flush in 3rd EXEC cycle of REM
    stall_cfg = 10;
    send(MDU_REM, 32'd50, 32'd8, 5'd5);
    tick();
    req_valid = 1'b0;
    #1 chk("rem_exec1", {31'b0, mdu_req}, 32'd1);
    tick();
    chk("rem_exec2", {31'b0, mdu_req}, 32'd1);
    tick();
    flush = 1'b1;
    #1;
    chk("rem_flush_kill", {29'b0, mdu_kill, req_ready, mdu_req}, 32'h5);
    tick();
    flush = 1'b0;
    #1;
    chk("rem_after_flush", {28'b0, mdu_req, mdu_kill, req_ready, rsp_valid}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rem_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    stall_cfg = 0;

    // Flush in HOLD drops the result
    rsp_ready = 1'b0;
    send(MDU_MUL, 32'd5, 32'd5, 5'd1);
    tick();
    req_valid = 1'b0;
    tick();
    chk("hflush_valid", {31'b0, rsp_valid}, 32'd1);
    chk("hflush_result", rsp_result, 32'd25);
    flush = 1'b1;
    #1 chk("hflush_kill_ready", {30'b0, mdu_kill, req_ready}, 32'd0);
    tick();
    flush = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("hflush_idle", {30'b0, rsp_valid, req_ready}, 32'd1);

    // Reset mid-EXEC
    stall_cfg = 10;
    send(MDU_DIV, 32'd20, 32'd3, 5'd6);
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1 chk("rst_exec_kill", {30'b0, mdu_kill, mdu_req}, 32'd1);
    tick();
    rst = 1'b0;
    #1 chk_reset_outputs("rst_exec");
    stall_cfg = 0;

    // Reset mid-HOLD
    rsp_ready = 1'b0;
    send(MDU_MUL, 32'd4, 32'd4, 5'd2);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst_hold_pre_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rst_hold_pre_result", rsp_result, 32'd16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1 chk_reset_outputs("rst_hold");

    // MULHU 0xFFFFFFFF * 2 twice
    send(MDU_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd10);
    tick();
    req_valid = 1'b0;
    #1 chk("mulhu1_exec", {31'b0, mdu_req}, 32'd1);
    tick();
    chk("mulhu1_valid", {31'b0, rsp_valid}, 32'd1);
    chk("mulhu1_result", rsp_result, 32'd1);
    tick();
    send(MDU_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd11);
    tick();
    req_valid = 1'b0;
    #1;
`ifdef MIRISCV_MDU_RESULT_CACHE_EN
    chk("mulhu2_hit_flags", {30'b0, rsp_valid, mdu_req}, 32'h2);
    chk("mulhu2_hit_result", rsp_result, 32'd1);
    chk("mulhu2_hit_rd", {27'b0, rsp_rd}, 32'd11);
    tick();
    chk("mulhu2_hit_done", {30'b0, rsp_valid, mdu_req}, 32'd0);
`else
    chk("mulhu2_exec_flags", {30'b0, rsp_valid, mdu_req}, 32'h1);
    tick();
    chk("mulhu2_valid", {31'b0, rsp_valid}, 32'd1);
    chk("mulhu2_result", rsp_result, 32'd1);
    chk("mulhu2_rd", {27'b0, rsp_rd}, 32'd11);
`endif
    tick();

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/miriscv_mdu_issue.md
MIRISCV_MDU_ISSUE -- requirements
Module: miriscv_mdu_issue

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL take parameters from packages, not module parameters: XLEN (miriscv_pkg), default 32, operand/result width; MDU_OP_WIDTH (miriscv_mdu_pkg), default 3, opcode width.
REQ-003 SHALL have ports:
  clk_i  in  1  clock
  rst_i  in  1  synchronous active-high reset
  req_valid_i  in  1  upstream request valid
  req_ready_o  out  1  upstream request accepted
  req_op_i  in  MDU_OP_WIDTH  MDU opcode
  req_a_i, req_b_i  in  XLEN  operands A/B
  req_rd_i  in  5  destination register tag
  flush_i  in  1  pipeline flush, cancels everything in flight
  mdu_req_o  out  1  request to MDU
  mdu_op_o  out  MDU_OP_WIDTH  latched opcode
  mdu_port_a_o, mdu_port_b_o  out  XLEN  latched operands
  mdu_kill_o  out  1  cancel MDU multicycle op
  mdu_keep_o  out  1  MDU hold result
  mdu_result_i  in  XLEN  MDU result
  mdu_stall_req_i  in  1  MDU busy
  rsp_valid_o  out  1  result valid to writeback
  rsp_ready_i  in  1  writeback accepts
  rsp_result_o  out  XLEN  result
  rsp_rd_o  out  5  destination tag

Function
REQ-004 SHALL implement FSM IDLE, EXEC, HOLD; reset state IDLE.
REQ-005 SHALL assert req_ready_o = !flush_i & (IDLE | (HOLD & rsp_ready_i)).
REQ-006 SHALL, on accept (req_valid_i & req_ready_o), latch op/a/b/rd into operand registers and enter EXEC next cycle.
REQ-007 SHALL drive mdu_req_o = 1 in EXEC only, with mdu_op_o/mdu_port_*_o from operand registers, stable for the whole EXEC stay.
REQ-008 SHALL, in EXEC with mdu_stall_req_i = 0 and flush_i = 0, capture mdu_result_i into the result register and enter HOLD.
REQ-009 SHALL assert rsp_valid_o in HOLD only; rsp_result_o/rsp_rd_o stable while rsp_valid_o & !rsp_ready_i.
REQ-010 SHALL leave HOLD on rsp_ready_i: to EXEC if a new request is accepted that cycle, else IDLE.
REQ-011 SHALL drive mdu_keep_o = 1 in HOLD while rsp_ready_i = 0, else 0.
REQ-012 SHALL, on flush_i in EXEC, assert mdu_kill_o combinationally that cycle, discard the op, enter IDLE; mdu_kill_o = 0 in all other cases.
REQ-013 SHALL, on flush_i in HOLD, drop the result (no rsp handshake) and enter IDLE; flush_i in IDLE is a no-op.
REQ-014 SHALL give minimum latency accept cycle N -> rsp_valid_o at N+2 (MDU no stall); each MDU stall cycle adds one.
REQ-015 SHALL pass operands unmodified; opcode semantics, div-by-zero and overflow are the MDU's.

Reset
REQ-016 SHALL, with rst_i = 1 at a clock edge, go to IDLE, clear all registers; outputs after reset: req_ready_o=1, mdu_req_o=0, mdu_kill_o=0, mdu_keep_o=0, rsp_valid_o=0, all data outputs 0.
REQ-017 SHALL, on reset mid-EXEC, not assert mdu_kill_o; MDU is reset by its own reset.

Configuration
REQ-018 SHALL, with MIRISCV_MDU_RESULT_CACHE_EN defined, keep a single-entry cache {valid, op, a, b, result}, written on each EXEC->HOLD capture, cleared on reset.
REQ-019 SHALL, with the macro, on accept of a request whose {op,a,b} equals a valid entry, skip EXEC, load result from cache, enter HOLD next cycle (rsp_valid_o at N+1), mdu_req_o never asserted; flush does not invalidate the entry.
REQ-020 SHALL, without the macro, contain no cache logic; every request goes through EXEC.

Structure
REQ-021 SHALL place state enum mdu_issue_state_e in miriscv_mdu_pkg next to the MDU opcode encodings; no new package.
REQ-022 SHALL put the cache in sub-module miriscv_mdu_rescache, instantiated only under the macro.

Verification
REQ-023 MDU_MUL a=3 b=5, MDU model stall 0 -> mdu_req_o 1 cycle, rsp_valid_o at N+2, result 15, rd echoed.
REQ-024 MDU_DIV a=100 b=7, model stall 33 cycles -> operands stable 34 EXEC cycles, rsp_result_o=14 at N+35.
REQ-025 rsp_ready_i low 5 cycles in HOLD -> result stable, mdu_keep_o=1 for 5 cycles, req_ready_o=0; back-to-back request accepted on ready cycle, EXEC next cycle.
REQ-026 flush_i in 3rd EXEC cycle of MDU_REM -> mdu_kill_o=1 that cycle, IDLE next, no rsp_valid_o.
REQ-027 rst_i mid-EXEC and mid-HOLD -> all outputs reset values next cycle, no rsp_valid_o.
REQ-028 Macro on: MDU_MULHU 0xFFFFFFFF x 2 twice -> second gives 0x00000001 at N+1, mdu_req_o=0; macro off -> both via EXEC.
